video_sync_gen: RTL
===================

# video_sync_gen

Programmable raster timing generator that drives horizontal and vertical sync, data-enable and pixel coordinates for the display side of the single-buffer design. It emits the VSYNC that the downstream VSYNC input filter consumes and marks the vertical-blank boundary where the frame buffer swap is permitted. All outputs are registered and cycle-exact against a pair of free-running raster counters.

## Interface
- H_ACTIVE, 640, visible pixels per line (≥1)
- H_FRONT, 16, horizontal front porch clocks (≥1)
- H_SYNC, 96, hsync pulse width clocks (≥1)
- H_BACK, 48, horizontal back porch clocks (≥1)
- V_ACTIVE, 480, visible lines per frame (≥1)
- V_FRONT, 10, vertical front porch lines (≥1)
- V_SYNC, 2, vsync pulse width lines (≥1)
- V_BACK, 33, vertical back porch lines (≥1)
- HS_POL, 0, active level of hsync_out
- VS_POL, 0, active level of vsync_out
- clk  input  1  pixel clock; everything on rising edge
- reset  input  1  synchronous, active-low reset
- enable  input  1  advance raster one pixel per cycle when high
- hsync_out  output  1  horizontal sync, level HS_POL when active
- vsync_out  output  1  vertical sync, level VS_POL when active
- de  output  1  high while the position is inside the active window
- x  output  12  pixel column when de=1, else 0
- y  output  12  current line number (0..V_TOTAL-1)
- frame_start  output  1  one-cycle pulse at position (0,0)
- vblank_start  output  1  one-cycle pulse at position (0,V_ACTIVE); buffer-swap point

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; both ≤ 4096 (12-bit counters h, v).
- Line order: active, front porch, sync, back porch; frame order identical in lines.
- Horizontal phase FSM states ACTIVE, FRONT, SYNC, BACK; transitions at h = H_ACTIVE, H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC, and wrap at H_TOTAL back to ACTIVE. Vertical phase FSM same states, stepping only on horizontal wrap.
- Advance (enable=1): h←h+1; at h=H_TOTAL-1, h←0 and v←v+1; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- enable=0: h, v, hsync_out, vsync_out, de, x, y hold; frame_start and vblank_start forced 0. Pulses fire only on the cycle the position is entered, never repeated while held.
- Decode for position (h,v): hsync active iff H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC; vsync active iff V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC (whole lines, edges aligned to h=0); de = (h<H_ACTIVE)&&(v<V_ACTIVE).
- Reset (reset=0 at clk edge): h=H_TOTAL-1, v=V_TOTAL-1, both FSMs in BACK; hsync_out=~HS_POL, vsync_out=~VS_POL, de=0, x=0, y=V_TOTAL-1, frame_start=0, vblank_start=0. Reset mid-frame aborts the frame immediately; no partial pulse is emitted.
- Reset wins over enable in the same cycle.

## Timing
- Outputs are registered and describe the position held in the counters after the same edge: the edge that loads (h,v) also loads its decoded outputs (next-state decode, zero output lag).
- First enabled edge after reset release loads (0,0): frame_start=1, de=1, x=0, y=0.
- frame period = H_TOTAL·V_TOTAL enabled cycles; hsync width exactly H_SYNC cycles; vsync width exactly V_SYNC·H_TOTAL cycles.
- vblank_start and the vsync leading edge separated by V_FRONT·H_TOTAL cycles.

## Test plan
Small parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), HS_POL=VS_POL=0.
- Reset low 3 cycles, then release with enable=1 -> cycle 1 after release: frame_start=1, de=1, x=0, y=0; hsync_out=vsync_out=1 throughout reset.
- Free run one line -> de=1 for h=0..3 (x=0..3), hsync_out=0 exactly at h=5,6, x=0 at h=4..7.
- Free run full frame -> vblank_start single pulse at (0,3); vsync_out=0 for 8 cycles covering v=4; frame_start recurs after 48 enabled cycles.
- Toggle enable low for 5 cycles at (0,3) entry cycle+1 -> all outputs hold, vblank_start not re-asserted, timing resumes exactly where it stopped.
- Assert reset at (2,4) during vsync -> next cycle vsync_out=1, de=0, y=5; no frame_start until first enabled cycle after release.
- Default parameters, 2 frames -> 800·525 cycles per frame, hsync 96 cycles, vsync 1600 cycles.

Source files
------------

// File: rtl/video_sync_gen.sv
// video_sync_gen: programmable raster timing generator with registered sync, data-enable and coordinate outputs
module video_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        vblank_start
);
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_FP   = 12'(H_ACTIVE);
  localparam logic [11:0] H_SP   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_BP   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_FP   = 12'(V_ACTIVE);
  localparam logic [11:0] V_SP   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] V_BP   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  logic [11:0] h, v, h_nxt, v_nxt;
  logic        h_wrap, de_nxt;
  phase_t      hp, vp, hp_nxt, vp_nxt;
  // next raster position and the phase it lands in; outputs are decoded from this so they carry no lag
  always_comb begin
    h_wrap = h == H_LAST;
    h_nxt  = h_wrap ? 12'd0 : h + 12'd1;
    v_nxt  = !h_wrap ? v : (v == V_LAST) ? 12'd0 : v + 12'd1;
    hp_nxt = (h_nxt == 12'd0) ? ACTIVE : (h_nxt == H_FP) ? FRONT :
             (h_nxt == H_SP) ? SYNC : (h_nxt == H_BP) ? BACK : hp;
    vp_nxt = !h_wrap ? vp : (v_nxt == 12'd0) ? ACTIVE : (v_nxt == V_FP) ? FRONT :
             (v_nxt == V_SP) ? SYNC : (v_nxt == V_BP) ? BACK : vp;
    de_nxt = hp_nxt == ACTIVE && vp_nxt == ACTIVE;
  end
  // counters, phase FSMs and registered outputs; pulses only on the enabled cycle a position is entered
  always_ff @(posedge clk) begin
    if (!reset) begin
      h            <= H_LAST;
      v            <= V_LAST;
      hp           <= BACK;
      vp           <= BACK;
      hsync_out    <= ~HS_POL;
      vsync_out    <= ~VS_POL;
      de           <= 1'b0;
      x            <= 12'd0;
      y            <= V_LAST;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      if (enable) begin
        h            <= h_nxt;
        v            <= v_nxt;
        hp           <= hp_nxt;
        vp           <= vp_nxt;
        hsync_out    <= (hp_nxt == SYNC) ? HS_POL : ~HS_POL;
        vsync_out    <= (vp_nxt == SYNC) ? VS_POL : ~VS_POL;
        de           <= de_nxt;
        x            <= de_nxt ? h_nxt : 12'd0;
        y            <= v_nxt;
        frame_start  <= h_nxt == 12'd0 && v_nxt == 12'd0;
        vblank_start <= h_nxt == 12'd0 && v_nxt == V_FP;
      end
    end
  end
endmodule
